mem_arb_seq: RTL and testbench

- Arbitrates the shared DRAM array between CPU, bus and refresh requesters.
- Sequences RAS/CAS/MWRITE_n for each granted cycle.
- Contains an internal refresh-interval timer with a pending-refresh counter.
- Sits between the address decoder (request generation) and the RAM array/ECC datapath in the memory top level. Replaces the free-running request/grant latch logic with one synchronous FSM on sysclk.

---
 rtl/mem_arb_pkg.sv | 35 +++
 rtl/mem_ref_timer.sv | 54 +++++
 rtl/mem_arb_seq.sv | 163 ++++++++++++++++
 tb/tb_mem_arb_seq.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default DRAM timing for the memory arbiter/sequencer.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ROW  = 3'd1,
    ST_COL  = 3'd2,
    ST_REF  = 3'd3,
    ST_PRE  = 3'd4
  } arb_state_e;

  typedef enum logic [1:0] {
    REQ_CPU = 2'd0,
    REQ_BUS = 2'd1,
    REQ_REF = 2'd2
  } req_id_e;

  localparam int T_RCD_DEF        = 2;
  localparam int T_CAS_DEF        = 2;
  localparam int T_RP_DEF         = 2;
  localparam int T_RAS_REF_DEF    = 4;
  localparam int REF_INTERVAL_DEF = 780;

  // Duration counters are loaded with T-1, so they only need to hold max(T)-1.
  function automatic int dur_width(input int a, input int b, input int c, input int d);
    int m;
    m = 2;
    if (a > m) m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/mem_ref_timer.sv
// Refresh-interval timer with a saturating pending-refresh count and sticky overrun flag.
module mem_ref_timer
  import mem_arb_pkg::*;
#(
  parameter int REF_INTERVAL = REF_INTERVAL_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic ref_taken,
  output logic pending_nz,
  output logic REF_OVF
);

  localparam int TW = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;

  logic [TW-1:0] timer_r;
  logic [1:0]    pending_r;
  logic          wrap_s;

  assign wrap_s     = (timer_r == TW'(REF_INTERVAL - 1));
  assign pending_nz = (pending_r != 2'd0);

  // Free-running interval counter, active in every arbiter state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_r <= '0;
    end else if (wrap_s) begin
      timer_r <= '0;
    end else begin
      timer_r <= timer_r + TW'(1);
    end
  end

  // A wrap and a refresh start on the same edge cancel out; a wrap with no room flags overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_r <= 2'd0;
      REF_OVF   <= 1'b0;
    end else begin
      case ({wrap_s, ref_taken})
        2'b10: begin
          if (pending_r == 2'd3) begin
            REF_OVF <= 1'b1;
          end else begin
            pending_r <= pending_r + 2'd1;
          end
        end
        2'b01:   pending_r <= pending_r - 2'd1;
        default: pending_r <= pending_r;
      endcase
    end
  end

endmodule

// File: rtl/mem_arb_seq.sv
// DRAM arbiter for CPU, bus and refresh, sequencing RAS/CAS/MWRITE_n for each granted cycle.
module mem_arb_seq
  import mem_arb_pkg::*;
#(
  parameter int T_RCD        = T_RCD_DEF,
  parameter int T_CAS        = T_CAS_DEF,
  parameter int T_RP         = T_RP_DEF,
  parameter int T_RAS_REF    = T_RAS_REF_DEF,
  parameter int REF_INTERVAL = REF_INTERVAL_DEF
) (
  input  logic sysclk,
  input  logic sys_rst,
  input  logic CLRQ_n,
  input  logic BLRQ_n,
  input  logic CWRITE,
  input  logic BWRITE,
  output logic CGNT_n,
  output logic BGNT_n,
  output logic RGNT_n,
  output logic RAS,
  output logic CAS,
  output logic MWRITE_n,
  output logic DRY,
  output logic REF_OVF,
  output logic BUSY
);

  localparam int DUR_W = dur_width(T_RCD, T_CAS, T_RP, T_RAS_REF);

  arb_state_e       state_r;
  logic [DUR_W-1:0] dur_cnt_r;
  req_id_e          owner_r;
  req_id_e          last_r;

  logic cpu_req_s;
  logic bus_req_s;
  logic pick_cpu_s;
  logic pick_bus_s;
  logic pick_wr_s;
  logic pending_nz_s;
  logic ref_taken_s;
  logic dur_done_s;

  assign cpu_req_s   = !CLRQ_n;
  assign bus_req_s   = !BLRQ_n;
  // On a tie the requester that was not served last wins.
  assign pick_cpu_s  = cpu_req_s && (!bus_req_s || (last_r == REQ_BUS));
  assign pick_bus_s  = bus_req_s && !pick_cpu_s;
  assign pick_wr_s   = pick_cpu_s ? CWRITE : BWRITE;
  assign ref_taken_s = (state_r == ST_IDLE) && pending_nz_s;
  assign dur_done_s  = (dur_cnt_r == '0);

  mem_ref_timer #(
    .REF_INTERVAL(REF_INTERVAL)
  ) u_ref_timer (
    .clk       (sysclk),
    .rst       (sys_rst),
    .ref_taken (ref_taken_s),
    .pending_nz(pending_nz_s),
    .REF_OVF   (REF_OVF)
  );

  // Arbitration and strobe sequencing FSM with registered outputs.
  always_ff @(posedge sysclk or posedge sys_rst) begin
    if (sys_rst) begin
      state_r   <= ST_IDLE;
      dur_cnt_r <= '0;
      owner_r   <= REQ_CPU;
      last_r    <= REQ_CPU;
      CGNT_n    <= 1'b1;
      BGNT_n    <= 1'b1;
      RGNT_n    <= 1'b1;
      RAS       <= 1'b0;
      CAS       <= 1'b0;
      MWRITE_n  <= 1'b1;
      DRY       <= 1'b0;
      BUSY      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pending_nz_s) begin
            state_r   <= ST_REF;
            dur_cnt_r <= DUR_W'(T_RAS_REF - 1);
            owner_r   <= REQ_REF;
            RGNT_n    <= 1'b0;
            RAS       <= 1'b1;
            MWRITE_n  <= 1'b1;
            BUSY      <= 1'b1;
          end else if (pick_cpu_s || pick_bus_s) begin
            state_r   <= ST_ROW;
            dur_cnt_r <= DUR_W'(T_RCD - 1);
            owner_r   <= pick_cpu_s ? REQ_CPU : REQ_BUS;
            CGNT_n    <= !pick_cpu_s;
            BGNT_n    <= !pick_bus_s;
            RAS       <= 1'b1;
            // The write qualifier is captured here and held until precharge.
            MWRITE_n  <= !pick_wr_s;
            BUSY      <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ROW: begin
          if (dur_done_s) begin
            state_r   <= ST_COL;
            dur_cnt_r <= DUR_W'(T_CAS - 1);
            CAS       <= 1'b1;
            DRY       <= (T_CAS == 1);
          end else begin
            dur_cnt_r <= dur_cnt_r - DUR_W'(1);
          end
        end
        ST_COL: begin
          if (dur_done_s) begin
            state_r   <= ST_PRE;
            dur_cnt_r <= DUR_W'(T_RP - 1);
            last_r    <= owner_r;
            CGNT_n    <= 1'b1;
            BGNT_n    <= 1'b1;
            RAS       <= 1'b0;
            CAS       <= 1'b0;
            MWRITE_n  <= 1'b1;
            DRY       <= 1'b0;
          end else begin
            dur_cnt_r <= dur_cnt_r - DUR_W'(1);
            DRY       <= (dur_cnt_r == DUR_W'(1));
          end
        end
        ST_REF: begin
          if (dur_done_s) begin
            state_r   <= ST_PRE;
            dur_cnt_r <= DUR_W'(T_RP - 1);
            RGNT_n    <= 1'b1;
            RAS       <= 1'b0;
          end else begin
            dur_cnt_r <= dur_cnt_r - DUR_W'(1);
          end
        end
        ST_PRE: begin
          if (dur_done_s) begin
            state_r <= ST_IDLE;
            BUSY    <= 1'b0;
          end else begin
            dur_cnt_r <= dur_cnt_r - DUR_W'(1);
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          dur_cnt_r <= '0;
          CGNT_n    <= 1'b1;
          BGNT_n    <= 1'b1;
          RGNT_n    <= 1'b1;
          RAS       <= 1'b0;
          CAS       <= 1'b0;
          MWRITE_n  <= 1'b1;
          DRY       <= 1'b0;
          BUSY      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arb_seq.sv
// Directed and randomized bench for mem_arb_seq, checked against a transaction-level timing model.
module tb_mem_arb_seq;

  localparam int RI    = 780;
  localparam int TRCD  = 2;
  localparam int TCAS  = 2;
  localparam int TRP   = 2;
  localparam int TRASR = 4;

  logic sysclk = 1'b0;
  logic sys_rst = 1'b1;
  logic rst2 = 1'b1;
  logic CLRQ_n = 1'b1, BLRQ_n = 1'b1, CWRITE = 1'b0, BWRITE = 1'b0;
  logic CGNT_n, BGNT_n, RGNT_n, RAS, CAS, MWRITE_n, DRY, REF_OVF, BUSY;
  logic o2_cgnt, o2_bgnt, o2_rgnt, o2_ras, o2_cas, o2_mw, o2_dry, o2_ovf, o2_busy;

  int checks = 0;
  int errors = 0;

  // Model state: current job (0 none, 1 cpu, 2 bus, 3 refresh) and the edge it started on.
  int m_edge, m_job, m_start, m_last, m_pending;
  logic m_wr, m_ovf;
  logic [8:0] rd_tbl [1:7];

  mem_arb_seq dut (
    .sysclk(sysclk), .sys_rst(sys_rst), .CLRQ_n(CLRQ_n), .BLRQ_n(BLRQ_n),
    .CWRITE(CWRITE), .BWRITE(BWRITE), .CGNT_n(CGNT_n), .BGNT_n(BGNT_n),
    .RGNT_n(RGNT_n), .RAS(RAS), .CAS(CAS), .MWRITE_n(MWRITE_n), .DRY(DRY),
    .REF_OVF(REF_OVF), .BUSY(BUSY)
  );

  // Stalled instance: long row phase and a tiny refresh interval starve refresh on purpose.
  mem_arb_seq #(.REF_INTERVAL(2), .T_RCD(8)) dut_ovf (
    .sysclk(sysclk), .sys_rst(rst2), .CLRQ_n(1'b1), .BLRQ_n(1'b0),
    .CWRITE(1'b0), .BWRITE(1'b0), .CGNT_n(o2_cgnt), .BGNT_n(o2_bgnt),
    .RGNT_n(o2_rgnt), .RAS(o2_ras), .CAS(o2_cas), .MWRITE_n(o2_mw), .DRY(o2_dry),
    .REF_OVF(o2_ovf), .BUSY(o2_busy)
  );

  always #5 sysclk = ~sysclk;

  task automatic model_reset();
    m_edge = 0; m_job = 0; m_start = 0; m_last = 0; m_pending = 0;
    m_wr = 1'b0; m_ovf = 1'b0;
  endtask

  task automatic model_edge();
    int tot;
    bit wrap, take, c, b;
    m_edge++;
    wrap = ((m_edge % RI) == 0);
    take = 1'b0;
    tot = (m_job == 3) ? (TRASR + TRP) : (TRCD + TCAS + TRP);
    if (m_job == 0 || (m_edge - m_start) > tot) begin
      m_job = 0;
      c = !CLRQ_n;
      b = !BLRQ_n;
      if (m_pending > 0) begin
        m_job = 3;
        take = 1'b1;
      end else if (c && b) m_job = (m_last == 0) ? 2 : 1;
      else if (c) m_job = 1;
      else if (b) m_job = 2;
      if (m_job != 0) m_start = m_edge;
      if (m_job == 1) begin m_wr = CWRITE; m_last = 0; end
      if (m_job == 2) begin m_wr = BWRITE; m_last = 1; end
    end
    if (wrap && !take) begin
      if (m_pending == 3) m_ovf = 1'b1;
      else m_pending++;
    end else if (!wrap && take) begin
      m_pending--;
    end
  endtask

  function automatic logic [8:0] model_out();
    int d;
    logic gc, gb, gr, ras, cas, mw, dry, busy;
    gc = 1'b1; gb = 1'b1; gr = 1'b1; ras = 1'b0; cas = 1'b0; mw = 1'b1; dry = 1'b0; busy = 1'b0;
    d = m_edge - m_start;
    if (m_job == 3) begin
      if (d < TRASR) begin gr = 1'b0; ras = 1'b1; busy = 1'b1; end
      else if (d < TRASR + TRP) busy = 1'b1;
    end else if (m_job != 0) begin
      if (d < TRCD + TCAS) begin
        gc = (m_job != 1); gb = (m_job != 2);
        ras = 1'b1; mw = !m_wr; busy = 1'b1;
        cas = (d >= TRCD);
        dry = (d == TRCD + TCAS - 1);
      end else if (d < TRCD + TCAS + TRP) busy = 1'b1;
    end
    return {gc, gb, gr, ras, cas, mw, dry, m_ovf, busy};
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%b exp=%b", tag, obs, exp);
    end
  endtask

  task automatic chk9(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0t obs=%b exp=%b", tag, $time, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [8:0] obs;
    obs = {CGNT_n, BGNT_n, RGNT_n, RAS, CAS, MWRITE_n, DRY, REF_OVF, BUSY};
    chk9("outs_vs_model", obs, model_out());
    checks++;
    assert (($countones({CGNT_n, BGNT_n, RGNT_n}) >= 2) && (!CAS || RAS)) else begin
      errors++;
      $error("FAIL safety obs_gnt=%b cas=%b ras=%b exp=one_grant_cas_with_ras", {CGNT_n, BGNT_n, RGNT_n}, CAS, RAS);
    end
  endtask

  task automatic step();
    @(posedge sysclk);
    model_edge();
    #2;
    check_all();
  endtask

  initial begin
    rd_tbl[1] = 9'b011101001; rd_tbl[2] = 9'b011101001;
    rd_tbl[3] = 9'b011111001; rd_tbl[4] = 9'b011111101;
    rd_tbl[5] = 9'b111001001; rd_tbl[6] = 9'b111001001;
    rd_tbl[7] = 9'b111001000;

    // Reset state
    model_reset();
    #7;
    check_all();
    chk9("reset_outs", {CGNT_n, BGNT_n, RGNT_n, RAS, CAS, MWRITE_n, DRY, REF_OVF, BUSY}, 9'b111001000);
    chk1("ovf2_reset", o2_ovf, 1'b0);
    #5;
    sys_rst = 1'b0;
    rst2 = 1'b0;

    // Held tie after reset: bus, cpu, bus
    CLRQ_n = 1'b0; BLRQ_n = 1'b0;
    for (int i = 1; i <= 21; i++) begin
      step();
      if (i == 1)  chk9("tie_1_bus", {7'd0, CGNT_n, BGNT_n}, 9'b000000010);
      if (i == 8)  chk9("tie_2_cpu", {7'd0, CGNT_n, BGNT_n}, 9'b000000001);
      if (i == 15) chk9("tie_3_bus", {7'd0, CGNT_n, BGNT_n}, 9'b000000010);
    end
    CLRQ_n = 1'b1; BLRQ_n = 1'b1;
    chk1("ovf2_set", o2_ovf, 1'b1);

    // CPU read from an idle machine
    CLRQ_n = 1'b0; CWRITE = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      step();
      CLRQ_n = 1'b1;
      chk9($sformatf("cpu_read_c%0d", i), {CGNT_n, BGNT_n, RGNT_n, RAS, CAS, MWRITE_n, DRY, REF_OVF, BUSY}, rd_tbl[i]);
    end

    // Bus write; BWRITE drops after the grant and must be ignored
    BLRQ_n = 1'b0; BWRITE = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step();
      BLRQ_n = 1'b1;
      BWRITE = 1'b0;
      if (i <= 4) chk1($sformatf("bus_wr_mw_c%0d", i), MWRITE_n, 1'b0);
      if (i == 5) chk1("bus_wr_mw_pre", MWRITE_n, 1'b1);
    end

    // Async reset in the middle of a CPU column phase
    CLRQ_n = 1'b0;
    step();
    CLRQ_n = 1'b1;
    step();
    step();
    chk1("mid_col_cas", CAS, 1'b1);
    sys_rst = 1'b1;
    #1;
    model_reset();
    chk9("async_rst_outs", {CGNT_n, BGNT_n, RGNT_n, RAS, CAS, MWRITE_n, DRY, REF_OVF, BUSY}, 9'b111001000);
    check_all();
    #4;
    sys_rst = 1'b0;
    CLRQ_n = 1'b0; BLRQ_n = 1'b0;
    step();
    chk9("post_rst_tie_bus", {7'd0, CGNT_n, BGNT_n}, 9'b000000010);
    CLRQ_n = 1'b1; BLRQ_n = 1'b1;
    for (int i = 0; i < 7; i++) step();

    // Refresh with no requests pending
    for (int i = 0; i < 900 && m_pending == 0; i++) step();
    for (int i = 1; i <= 4; i++) begin
      step();
      chk1($sformatf("ref_rgnt_c%0d", i), RGNT_n, 1'b0);
      chk1($sformatf("ref_ras_c%0d", i), RAS, 1'b1);
      chk1($sformatf("ref_cas_c%0d", i), CAS, 1'b0);
      chk1($sformatf("ref_dry_c%0d", i), DRY, 1'b0);
    end
    for (int i = 0; i < 3; i++) step();

    // Refresh wins over a simultaneous CPU request; CPU follows after precharge
    for (int i = 0; i < 900 && m_pending == 0; i++) step();
    CLRQ_n = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i == 1) chk9("ref_vs_cpu_ref", {6'd0, CGNT_n, BGNT_n, RGNT_n}, 9'b000000110);
      if (i == 8) chk9("ref_vs_cpu_cpu", {6'd0, CGNT_n, BGNT_n, RGNT_n}, 9'b000000011);
    end
    CLRQ_n = 1'b1;

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      CLRQ_n = ($urandom_range(0, 1) == 0);
      BLRQ_n = ($urandom_range(0, 1) == 0);
      CWRITE = $urandom_range(0, 1);
      BWRITE = $urandom_range(0, 1);
      step();
    end

    chk1("ovf2_sticky", o2_ovf, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
